// File: rtl/reg_arb_pkg.sv
// Shared widths and request record for the register-file arbiter.
package reg_arb_pkg;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 8;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    logic           we;
    reg_idx_t       rs;
    reg_idx_t       rt;
    reg_idx_t       rd;
    logic [DW-1:0]  wdata;
  } reg_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter. REG_ARB_ROUND_ROBIN_EN selects a rotating pointer;
// without it the lowest index always wins and no pointer state exists.
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

`ifdef REG_ARB_ROUND_ROBIN_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;

  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end
`else
  // Fixed priority: requester 0 may starve the rest, intended for single-master builds.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares one register-file port between NREQ requesters; reads respond one cycle later.
// Build option REG_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: fixed priority).
module reg_file_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_rs,
  input  logic [NREQ*AW-1:0] req_rt,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    resp_valid,
  output logic [DW-1:0]      resp_rs_data,
  output logic [DW-1:0]      resp_rt_data,
  output logic               rf_rw,
  output logic [AW-1:0]      rf_rs,
  output logic [AW-1:0]      rf_rt,
  output logic [AW-1:0]      rf_rd,
  output logic [DW-1:0]      rf_wdata,
  input  logic [DW-1:0]      rf_rs_data,
  input  logic [DW-1:0]      rf_rt_data
);

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rd_issue;
  reg_req_t        sel;

  // Nothing may be accepted while reset is held.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid & {NREQ{~reset}}),
    .advance (|grant),
    .grant   (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.we    = req_we[i];
        sel.rs    = req_rs[i*AW +: AW];
        sel.rt    = req_rt[i*AW +: AW];
        sel.rd    = req_rd[i*AW +: AW];
        sel.wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign rf_rw    = sel.we;
  assign rf_rs    = sel.rs;
  assign rf_rt    = sel.rt;
  assign rf_rd    = sel.rd;
  assign rf_wdata = sel.wdata;

  assign rd_issue = grant & ~req_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= '0;
    end else begin
      resp_valid <= rd_issue;
    end
  end

  // Register-file read data is already registered, so it lines up with resp_valid.
  assign resp_rs_data = rf_rs_data;
  assign resp_rt_data = rf_rt_data;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter with a behavioural register file behind it.
// Expected arbitration follows REG_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_reg_file_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_rs, req_rt, req_rd;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_rs_data, resp_rt_data;
  logic               rf_rw;
  logic [AW-1:0]      rf_rs, rf_rt, rf_rd;
  logic [DW-1:0]      rf_wdata;
  logic [DW-1:0]      rf_rs_data, rf_rt_data;

  always #5 clk = ~clk;

  reg_file_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rs_data(resp_rs_data), .resp_rt_data(resp_rt_data),
    .rf_rw(rf_rw), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data)
  );

  // Register file: r0 hardwired to zero, registered read data, cleared by reset.
  logic [DW-1:0] rf_mem [8];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_rs_data <= '0;
      rf_rt_data <= '0;
    end else begin
      if (rf_rw && rf_rd != 3'd0) rf_mem[rf_rd] <= rf_wdata;
      rf_rs_data <= (rf_rs == 3'd0) ? 8'h00 : rf_mem[rf_rs];
      rf_rt_data <= (rf_rt == 3'd0) ? 8'h00 : rf_mem[rf_rt];
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
  } resp_t;

  resp_t      sb_q[$];
  logic [7:0] mdl_reg [8];
  int         mdl_ptr;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_gnt1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd, input logic [7:0] wd);
    req_valid[i]        = v;
    req_we[i]           = we;
    req_rs[i*AW +: AW]  = rs;
    req_rt[i*AW +: AW]  = rt;
    req_rd[i*AW +: AW]  = rd;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
  endtask

  function automatic int expected_grant(input logic [NREQ-1:0] v);
    int g;
    g = -1;
`ifdef REG_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && v[(mdl_ptr + k) % NREQ]) g = (mdl_ptr + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && v[k]) g = k;
`endif
    return g;
  endfunction

  task automatic check_resp();
    resp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("resp_valid", 32'(resp_valid), 32'(1 << e.idx));
      check("resp_rs_data", 32'(resp_rs_data), 32'(e.rs_data));
      check("resp_rt_data", 32'(resp_rt_data), 32'(e.rt_data));
    end else begin
      check("resp_idle", 32'(resp_valid), 32'(0));
    end
  endtask

  // Inputs are already driven (after a negedge); check grant, advance one clock, check response.
  task automatic tick();
    int         g;
    logic [2:0] rs, rt, rd;
    resp_t      e;
    #1;
    g = reset ? -1 : expected_grant(req_valid);
    check("req_ready", 32'(req_ready), (g < 0) ? 32'(0) : 32'(1 << g));
    check("rf_rw", 32'(rf_rw), (g < 0) ? 32'(0) : 32'(req_we[g]));
    if (g == 1) n_gnt1++;
    if (g >= 0) begin
      rs = req_rs[g*AW +: AW];
      rt = req_rt[g*AW +: AW];
      rd = req_rd[g*AW +: AW];
      if (req_we[g]) begin
        check("rf_rd", 32'(rf_rd), 32'(rd));
        check("rf_wdata", 32'(rf_wdata), 32'(req_wdata[g*DW +: DW]));
      end else begin
        e.idx = g;
        e.rs_data = mdl_reg[rs];
        e.rt_data = mdl_reg[rt];
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    if (reset) begin
      mdl_ptr = 0;
      for (int i = 0; i < 8; i++) mdl_reg[i] = 8'h00;
    end else if (g >= 0) begin
      mdl_ptr = (g + 1) % NREQ;
      if (req_we[g] && rd != 3'd0) mdl_reg[rd] = req_wdata[g*DW +: DW];
    end
    @(negedge clk);
    check_resp();
  endtask

  initial begin
    mdl_ptr = 0;
    for (int i = 0; i < 8; i++) mdl_reg[i] = 8'h00;
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    tick();
    tick();
    check("reset_rf_rw", 32'(rf_rw), 32'(0));
    reset = 1'b0;

    // write r3 then read r3/r0
    set_req(0, 1, 1, 3'd0, 3'd0, 3'd3, 8'h5A);
    tick();
    set_req(0, 1, 0, 3'd3, 3'd0, 3'd0, 8'h00);
    tick();
    idle_all();
    tick();

    // both requesters read continuously
    n_gnt1 = 0;
    set_req(0, 1, 0, 3'd3, 3'd7, 3'd0, 8'h00);
    set_req(1, 1, 0, 3'd5, 3'd3, 3'd0, 8'h00);
    repeat (6) tick();
`ifdef REG_ARB_ROUND_ROBIN_EN
    check("rr_req1_grants", 32'(n_gnt1), 32'(3));
`else
    check("fixed_req1_grants", 32'(n_gnt1), 32'(0));
`endif
    idle_all();
    tick();

    // write r7, write r0 (ignored), read r0/r7
    set_req(1, 1, 1, 3'd0, 3'd0, 3'd7, 8'hFF);
    tick();
    idle_all();
    set_req(0, 1, 1, 3'd0, 3'd0, 3'd0, 8'h11);
    tick();
    set_req(0, 1, 0, 3'd0, 3'd7, 3'd0, 8'h00);
    tick();
    idle_all();
    tick();

    // read with reset held: no grant, no response, state cleared
    set_req(0, 1, 0, 3'd7, 3'd3, 3'd0, 8'h00);
    tick();
    set_req(1, 1, 0, 3'd7, 3'd7, 3'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1, 0, 3'd7, 3'd3, 3'd0, 8'h00);
    tick();
    check("post_reset_read_rs", 32'(resp_rs_data), 32'(0));
    idle_all();
    tick();

    // req1 holds a write for 3 cycles with req0 idle
    set_req(1, 1, 1, 3'd0, 3'd0, 3'd5, 8'h33);
    repeat (3) tick();
    idle_all();
    tick();
    set_req(0, 1, 0, 3'd5, 3'd5, 3'd0, 8'h00);
    tick();
    idle_all();
    tick();

    // random mix
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      tick();
    end
    idle_all();
    tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
